// File: rtl/mul_div_unit_pkg.sv
// Shared types for the execute-stage arithmetic units: ALU and multiply/divide
// operation encodings, the multiply/divide sequencer states, and small decode
// helpers used when an operation is accepted.
package mul_div_unit_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluOperations;

    // Encoding follows funct3 of the RV32M instructions.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdOperations;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdState;

    // Divide-family operations all have funct3[2] set.
    function automatic logic md_is_div(input mdOperations o);
        return o[2];
    endfunction

    // rs1 is treated as signed for these operations.
    function automatic logic md_signed1(input mdOperations o);
        return (o == MULH) || (o == MULHSU) || (o == DIV) || (o == REM);
    endfunction

    // rs2 is treated as signed for these operations.
    function automatic logic md_signed2(input mdOperations o);
        return (o == MULH) || (o == DIV) || (o == REM);
    endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negation. Used both to take operand magnitudes
// before iterating and to restore the sign of the finished product, quotient
// and remainder.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] fixed
);

    // Pass through or negate depending on the requested sign.
    always_comb begin
        fixed = value;
        if (negate) begin
            fixed = ~value + W'(1);
        end else begin
            fixed = value;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit. Operands are reduced to magnitudes on
// accept, a 32-step shift-add multiply or restoring divide runs on a shared
// 2*XLEN accumulator, and the sign is applied to the final value. Division by
// zero and signed overflow bypass the iteration and complete in one cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  mdOperations      op,
    input  logic [XLEN-1:0]  data1,
    input  logic [XLEN-1:0]  data2,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ZERO_W   = {XLEN{1'b0}};

    mdState              state_r;
    mdOperations         op_r;
    logic [CNT_W-1:0]    count_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     a_r;
    logic [XLEN-1:0]     b_r;
    logic                neg_res_r;
    logic                neg_rem_r;
    logic [XLEN-1:0]     result_r;
    logic                in_ready_r;
    logic                busy_r;
    logic                done_r;

    logic                sign1_s;
    logic                sign2_s;
    logic [XLEN-1:0]     mag1_s;
    logic [XLEN-1:0]     mag2_s;
    logic                div_zero_s;
    logic                overflow_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s;
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       diff_s;
    logic [2*XLEN-1:0]   acc_next_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     final_res_s;

    assign sign1_s = md_signed1(op) & data1[XLEN-1];
    assign sign2_s = md_signed2(op) & data2[XLEN-1];

    md_sign_fix #(.W(XLEN)) u_mag1 (.value(data1), .negate(sign1_s), .fixed(mag1_s));
    md_sign_fix #(.W(XLEN)) u_mag2 (.value(data2), .negate(sign2_s), .fixed(mag2_s));

    assign div_zero_s = (data2 == ZERO_W);
    assign overflow_s = ((op == DIV) || (op == REM)) && (data1 == MIN_NEG) && (data2 == ALL_ONES);

    // Detect operations whose result is known without iterating.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = ZERO_W;
        if (md_is_div(op) && div_zero_s) begin
            special_s     = 1'b1;
            special_res_s = ((op == DIV) || (op == DIVU)) ? ALL_ONES : data1;
        end else if (overflow_s) begin
            special_s     = 1'b1;
            special_res_s = (op == DIV) ? MIN_NEG : ZERO_W;
        end else begin
            special_s     = 1'b0;
            special_res_s = ZERO_W;
        end
    end

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits becoming quotient}.
    assign sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, a_r};
    assign diff_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, b_r};

    // One shift-add or restoring-divide step of the shared accumulator.
    always_comb begin
        acc_next_s = acc_r;
        if (md_is_div(op_r)) begin
            if (!diff_s[XLEN]) begin
                acc_next_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {acc_r[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                acc_next_s = {sum_s, acc_r[XLEN-1:1]};
            end else begin
                acc_next_s = {1'b0, acc_r[2*XLEN-1:1]};
            end
        end
    end

    md_sign_fix #(.W(2*XLEN)) u_prod_fix (.value(acc_next_s), .negate(neg_res_r), .fixed(prod_s));
    md_sign_fix #(.W(XLEN)) u_quot_fix (.value(acc_next_s[XLEN-1:0]), .negate(neg_res_r), .fixed(quot_s));
    md_sign_fix #(.W(XLEN)) u_rem_fix (.value(acc_next_s[2*XLEN-1:XLEN]), .negate(neg_rem_r), .fixed(rem_s));

    // Pick the architectural result from the signed final accumulator.
    always_comb begin
        final_res_s = ZERO_W;
        case (op_r)
            MUL:                   final_res_s = prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU:   final_res_s = prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:             final_res_s = quot_s;
            REM, REMU:             final_res_s = rem_s;
            default:               final_res_s = ZERO_W;
        endcase
    end

    // Sequencer: accept, iterate XLEN steps, pulse done, return to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            op_r       <= MUL;
            count_r    <= '0;
            acc_r      <= '0;
            a_r        <= ZERO_W;
            b_r        <= ZERO_W;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            result_r   <= ZERO_W;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r       <= op;
                        a_r        <= mag1_s;
                        b_r        <= mag2_s;
                        neg_res_r  <= sign1_s ^ sign2_s;
                        neg_rem_r  <= sign1_s;
                        count_r    <= '0;
                        in_ready_r <= 1'b0;
                        acc_r      <= {ZERO_W, (md_is_div(op) ? mag1_s : mag2_s)};
                        if (special_s) begin
                            result_r <= special_res_s;
                            state_r  <= DONE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            state_r  <= CALC;
                            busy_r   <= 1'b1;
                            done_r   <= 1'b0;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b0;
                    end
                end
                CALC: begin
                    acc_r   <= acc_next_s;
                    count_r <= count_r + CNT_ONE;
                    if (count_r == CNT_LAST) begin
                        result_r <= final_res_s;
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        state_r  <= CALC;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;

endmodule
